// File: rtl/axis_frame_gen_m_pkg.sv
// Shared types and constants for the AXI4-Stream frame generator:
// FSM encoding, pattern modes, PRBS seed/taps and a width helper.
package axis_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FGAP = 2'd1,
        SEND = 2'd2,
        LGAP = 2'd3
    } state_e;

    localparam logic [1:0] MODE_CNT  = 2'd0;
    localparam logic [1:0] MODE_LINE = 2'd1;
    localparam logic [1:0] MODE_CHK  = 2'd2;
    localparam logic [1:0] MODE_PRBS = 2'd3;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 in a right-shifting register
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Bits needed to index 'value' distinct items (at least 1)
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) bits = i + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/axis_frame_gen_m_pattern_word.sv
// 32-bit pattern word selector with the PRBS register that feeds mode 3.
module axis_pattern_word
    import axis_gen_pkg::*;
#(
    parameter int BEAT_W      = 2,
    parameter int FRAME_CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   advance,
    input  logic                   reseed,
    input  logic [1:0]             mode,
    input  logic [FRAME_CNT_W-1:0] frame_cnt,
    input  logic [11:0]            line,
    input  logic [BEAT_W-1:0]      beat,
    output logic [31:0]            word
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Reseed wins over advance so the first beat of a frame always shows the seed
    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed) begin
            lfsr_d = LFSR_SEED;
        end else if (advance) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    always_comb begin
        word = 32'h0;
        case (mode)
            MODE_CNT:  word = {4'(frame_cnt), line, 16'(beat)};
            MODE_LINE: word = {20'h0, line};
            MODE_CHK:  word = (beat[0] ^ line[0]) ? 32'hFFFF_FFFF : 32'h0;
            MODE_PRBS: word = lfsr_q;
            default:   word = 32'h0;
        endcase
    end

endmodule

// File: rtl/axis_frame_gen_m.sv
// AXI4-Stream video test-pattern master: whole frames of lines with SOF on
// TUSER, EOL on TLAST, programmable line/frame gaps and four data patterns.
module axis_frame_gen_m
    import axis_gen_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int PIXELS_PER_BEAT      = 4,
    parameter int PIXELS_HORIZONTAL    = 1280,
    parameter int PIXELS_VERTICAL      = 1024,
    parameter int LINE_GAP             = 3,
    parameter int FRAME_GAP            = 1000,
    parameter int FRAME_CNT_W          = 4
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              enable,
    input  logic [1:0]                        mode,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TUSER,
    input  logic                              M_AXIS_TREADY,
    output logic                              frame_done,
    output logic [FRAME_CNT_W-1:0]            frame_cnt,
    output logic                              busy
);

    localparam int BEATS_PER_LINE = PIXELS_HORIZONTAL / PIXELS_PER_BEAT;
    localparam int BEAT_W         = clogb2(BEATS_PER_LINE);
    localparam int GAP_MAX        = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
    localparam int GAP_W          = (clogb2(GAP_MAX + 1) > 11) ? clogb2(GAP_MAX + 1) : 11;
    localparam int N_WORDS        = C_M_AXIS_TDATA_WIDTH / 32;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);
    localparam logic [11:0]       LAST_LINE = 12'(PIXELS_VERTICAL - 1);
    localparam logic [GAP_W-1:0]  LGAP_LOAD = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic [GAP_W-1:0]  FGAP_LOAD = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    state_e                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [11:0]            line_q, line_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [1:0]             mode_q, mode_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   tuser_q, tuser_d;
    logic                   busy_q, busy_d;
    logic                   xfer, frame_end, frame_start;
    logic [31:0]            pat_word;

    // Handshake: a beat moves when TVALID & TREADY at a rising edge; once
    // TVALID is up it stays up with TDATA/TLAST/TUSER frozen until it moves.
    assign xfer      = tvalid_q & M_AXIS_TREADY;
    assign frame_end = xfer & (beat_q == LAST_BEAT) & (line_q == LAST_LINE);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_d      = line_q;
        gap_d       = gap_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    mode_d      = mode;
                    line_d      = 12'd0;
                    beat_d      = '0;
                    frame_start = 1'b1;
                    gap_d       = FGAP_LOAD;
                    state_d     = (FRAME_GAP == 0) ? SEND : FGAP;
                end
            end
            FGAP, LGAP: begin
                if (gap_q == '0) state_d = SEND;
                else             gap_d   = gap_q - 1'b1;
            end
            SEND: begin
                if (xfer) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (line_q == LAST_LINE) begin
                            line_d      = 12'd0;
                            frame_cnt_d = frame_cnt_q + 1'b1;
                            if (enable) begin
                                mode_d      = mode;
                                frame_start = 1'b1;
                                gap_d       = FGAP_LOAD;
                                state_d     = (FRAME_GAP == 0) ? SEND : FGAP;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            line_d  = line_q + 12'd1;
                            gap_d   = LGAP_LOAD;
                            state_d = (LINE_GAP == 0) ? SEND : LGAP;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Qualifiers are derived from next state so they register alongside it
        tvalid_d = (state_d == SEND);
        tlast_d  = (state_d == SEND) && (beat_d == LAST_BEAT);
        tuser_d  = (state_d == SEND) && (line_d == 12'd0) && (beat_d == '0);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            line_q      <= 12'd0;
            gap_q       <= '0;
            mode_q      <= MODE_CNT;
            frame_cnt_q <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            gap_q       <= gap_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            busy_q      <= busy_d;
        end
    end

    axis_pattern_word #(
        .BEAT_W      (BEAT_W),
        .FRAME_CNT_W (FRAME_CNT_W)
    ) u_pattern (
        .clk       (M_AXIS_ACLK),
        .rst_n     (M_AXIS_ARESETN),
        .advance   (xfer),
        .reseed    (frame_start),
        .mode      (mode_q),
        .frame_cnt (frame_cnt_q),
        .line      (line_q),
        .beat      (beat_q),
        .word      (pat_word)
    );

    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = {N_WORDS{pat_word}};
    assign M_AXIS_TSTRB  = '1;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TUSER  = tuser_q;
    assign frame_done    = frame_end;
    assign frame_cnt     = frame_cnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_axis_frame_gen_m.sv
// Bench for axis_frame_gen_m: a 16x3 frame with gaps 2/5 (dut_a) and the
// same frame with no gaps (dut_b), checked beat-by-beat against a queue.
module tb_axis_frame_gen_m;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0, rnd_ready = 1'b0;
    logic [1:0]  mode_a = 2'd0, mode_b = 2'd0;
    logic        tready_a = 1'b1, tready_b = 1'b1;
    logic        tvalid_a, tlast_a, tuser_a, fd_a, busy_a;
    logic        tvalid_b, tlast_b, tuser_b, fd_b, busy_b;
    logic [31:0] tdata_a, tdata_b;
    logic [3:0]  tstrb_a, tstrb_b, fcnt_a, fcnt_b;

    int          checks = 0, errors = 0, cyc = 0, cyc_b = 0;
    logic [34:0] exp_q[$], exp_b_q[$], obs_q[$];
    int          sof_cyc[$], eof_cyc[$], b_cyc[$];

    always #5 clk = ~clk;

    axis_frame_gen_m #(
        .C_M_AXIS_TDATA_WIDTH(32), .PIXELS_PER_BEAT(4), .PIXELS_HORIZONTAL(16),
        .PIXELS_VERTICAL(3), .LINE_GAP(2), .FRAME_GAP(5), .FRAME_CNT_W(4)
    ) dut_a (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(arst_n), .enable(en_a), .mode(mode_a),
        .M_AXIS_TVALID(tvalid_a), .M_AXIS_TDATA(tdata_a), .M_AXIS_TSTRB(tstrb_a),
        .M_AXIS_TLAST(tlast_a), .M_AXIS_TUSER(tuser_a), .M_AXIS_TREADY(tready_a),
        .frame_done(fd_a), .frame_cnt(fcnt_a), .busy(busy_a)
    );

    axis_frame_gen_m #(
        .C_M_AXIS_TDATA_WIDTH(32), .PIXELS_PER_BEAT(4), .PIXELS_HORIZONTAL(16),
        .PIXELS_VERTICAL(3), .LINE_GAP(0), .FRAME_GAP(0), .FRAME_CNT_W(4)
    ) dut_b (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(arst_n), .enable(en_b), .mode(mode_b),
        .M_AXIS_TVALID(tvalid_b), .M_AXIS_TDATA(tdata_b), .M_AXIS_TSTRB(tstrb_b),
        .M_AXIS_TLAST(tlast_b), .M_AXIS_TUSER(tuser_b), .M_AXIS_TREADY(tready_b),
        .frame_done(fd_b), .frame_cnt(fcnt_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // Expected frame: 3 lines x 4 beats, entries are {frame_done, tuser, tlast, tdata}
    task automatic push_frame(input bit to_b, input int m, input int fc);
        logic [31:0] lf, d;
        logic [34:0] ent;
        lf = SEED;
        for (int ln = 0; ln < 3; ln++) begin
            for (int bt = 0; bt < 4; bt++) begin
                case (m)
                    0:       d = {fc[3:0], ln[11:0], bt[15:0]};
                    1:       d = {20'h0, ln[11:0]};
                    2:       d = (bt[0] ^ ln[0]) ? 32'hFFFF_FFFF : 32'h0;
                    default: d = lf;
                endcase
                ent = {(bt == 3 && ln == 2), (bt == 0 && ln == 0), (bt == 3), d};
                if (to_b) exp_b_q.push_back(ent);
                else      exp_q.push_back(ent);
                lf = lfsr_step(lf);
            end
        end
    endtask

    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_a || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL %s: timeout, %0d beats still expected", name, exp_q.size());
        end
    endtask

    task automatic wait_obs(input int k, input string name);
        int n;
        n = 0;
        while (obs_q.size() < k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL %s: timeout, got %0d beats expected %0d", name, obs_q.size(), k);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            tready_a = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor A: pops on every transfer, checks stall stability
    initial begin
        logic [34:0] got, prev;
        logic        stall_prev;
        stall_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (arst_n) begin
                got = {fd_a, tuser_a, tlast_a, tdata_a};
                if (stall_prev) chk("stall_hold", {tvalid_a, got[33:0]}, {1'b1, prev[33:0]});
                if (tvalid_a && tready_a) begin
                    obs_q.push_back(got);
                    if (tuser_a) sof_cyc.push_back(cyc);
                    if (fd_a) eof_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat_a: got %0h expected none", got);
                    end else begin
                        chk("beat_a", got, exp_q.pop_front());
                    end
                end else if (fd_a) begin
                    checks++; errors++;
                    $display("FAIL frame_done_no_xfer: got 1 expected 0");
                end
                stall_prev = tvalid_a && !tready_a;
                prev = got;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        logic [34:0] got;
        forever begin
            @(negedge clk);
            #1;
            cyc_b++;
            if (arst_n && tvalid_b && tready_b) begin
                got = {fd_b, tuser_b, tlast_b, tdata_b};
                b_cyc.push_back(cyc_b);
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat_b: got %0h expected none", got);
                end else begin
                    chk("beat_b", got, exp_b_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, nu, nl, nf;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tvalid", tvalid_a, 0);
        chk("rst_tlast", tlast_a, 0);
        chk("rst_tuser", tuser_a, 0);
        chk("rst_frame_done", fd_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_frame_cnt", fcnt_a, 0);
        chk("rst_tstrb", tstrb_a, 4'hF);
        chk("rst_tvalid_b", tvalid_b, 0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        // One-cycle enable pulse, mode 0, no backpressure
        obs_q.delete();
        push_frame(0, 0, 0);
        @(negedge clk); en_a = 1'b1; mode_a = 2'd0;
        @(negedge clk); en_a = 1'b0; lat = 1;
        while (!tvalid_a && lat < 100) begin @(negedge clk); lat++; end
        chk("latency_a", lat, 6);
        wait_idle_a("frame_t1");
        chk("t1_beats", obs_q.size(), 12);
        nu = 0; nl = 0; nf = 0;
        foreach (obs_q[i]) begin
            nu += int'(obs_q[i][33]);
            nl += int'(obs_q[i][32]);
            nf += int'(obs_q[i][34]);
        end
        chk("t1_tuser_count", nu, 1);
        chk("t1_tlast_count", nl, 3);
        chk("t1_frame_done_count", nf, 1);
        if (obs_q.size() >= 12) begin
            chk("t1_first_data", obs_q[0][31:0], 32'h0000_0000);
            chk("t1_last_data", obs_q[11][31:0], 32'h0002_0003);
        end
        chk("t1_frame_cnt", fcnt_a, 1);
        chk("t1_busy", busy_a, 0);

        // Same frame under random backpressure
        obs_q.delete();
        push_frame(0, 0, 1);
        rnd_ready = 1'b1;
        @(negedge clk); en_a = 1'b1;
        @(negedge clk); en_a = 1'b0;
        wait_idle_a("frame_t2");
        rnd_ready = 1'b0;
        chk("t2_beats", obs_q.size(), 12);
        chk("t2_frame_cnt", fcnt_a, 2);

        // Mode change mid-frame takes effect at the next frame
        obs_q.delete(); sof_cyc.delete(); eof_cyc.delete();
        push_frame(0, 0, 2);
        push_frame(0, 1, 3);
        @(negedge clk); en_a = 1'b1; mode_a = 2'd0;
        wait_obs(5, "t3_line1");
        mode_a = 2'd1;
        wait_obs(13, "t3_frame1");
        en_a = 1'b0;
        wait_idle_a("frame_t3");
        chk("t3_beats", obs_q.size(), 24);
        if (obs_q.size() >= 24) begin
            chk("t3_f0_line1_mode0", obs_q[4][31:0], 32'h2001_0000);
            for (int i = 20; i < 24; i++) chk("t3_f1_line2_id", obs_q[i][31:0], 32'h0000_0002);
        end
        if (sof_cyc.size() >= 2 && eof_cyc.size() >= 1)
            chk("t3_frame_gap_idle", sof_cyc[1] - eof_cyc[0] - 1, 5);
        else chk("t3_sof_eof_seen", sof_cyc.size() * 10 + eof_cyc.size(), 22);
        chk("t3_frame_cnt", fcnt_a, 4);

        // Zero gaps: continuous stream across line and frame boundaries
        push_frame(1, 2, 0);
        push_frame(1, 2, 1);
        @(negedge clk); en_b = 1'b1; mode_b = 2'd2;
        @(negedge clk); lat = 1;
        while (!tvalid_b && lat < 100) begin @(negedge clk); lat++; end
        chk("latency_b", lat, 1);
        lat = 0;
        while (b_cyc.size() < 13 && lat < 1000) begin @(negedge clk); lat++; end
        en_b = 1'b0;
        lat = 0;
        while ((busy_b || exp_b_q.size() != 0) && lat < 1000) begin @(negedge clk); lat++; end
        chk("b_beats", b_cyc.size(), 24);
        for (int i = 1; i < b_cyc.size(); i++) chk("b_no_idle", b_cyc[i] - b_cyc[i-1], 1);
        chk("b_frame_cnt", fcnt_b, 2);

        // PRBS over two frames
        obs_q.delete();
        push_frame(0, 3, 4);
        push_frame(0, 3, 5);
        @(negedge clk); en_a = 1'b1; mode_a = 2'd3;
        wait_obs(13, "t5_frame1");
        en_a = 1'b0;
        wait_idle_a("frame_t5");
        chk("t5_beats", obs_q.size(), 24);
        if (obs_q.size() >= 24) begin
            chk("t5_f0_seed", obs_q[0][31:0], 32'hACE1_2468);
            chk("t5_f0_step", obs_q[1][31:0], 32'h5670_9234);
            chk("t5_f1_seed", obs_q[12][31:0], 32'hACE1_2468);
            for (int i = 0; i < 12; i++) chk("t5_frames_equal", obs_q[i+12][31:0], obs_q[i][31:0]);
        end
        chk("t5_frame_cnt", fcnt_a, 6);

        // Reset mid-line, then restart from line 0
        obs_q.delete();
        push_frame(0, 0, 6);
        @(negedge clk); en_a = 1'b1; mode_a = 2'd0;
        wait_obs(6, "t6_mid_line1");
        arst_n = 1'b0; en_a = 1'b0;
        @(negedge clk); arst_n = 1'b1;
        chk("t6_tvalid", tvalid_a, 0);
        chk("t6_frame_cnt", fcnt_a, 0);
        chk("t6_busy", busy_a, 0);
        exp_q.delete(); obs_q.delete();
        push_frame(0, 0, 0);
        @(negedge clk); en_a = 1'b1;
        @(negedge clk); en_a = 1'b0;
        wait_idle_a("frame_t6");
        chk("t6_beats", obs_q.size(), 12);
        if (obs_q.size() >= 1) begin
            chk("t6_restart_tuser", obs_q[0][33], 1);
            chk("t6_restart_data", obs_q[0][31:0], 32'h0000_0000);
        end
        chk("t6_frame_cnt", fcnt_a, 1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_gen_m.md
Name: axis_frame_gen_m

Overview:
- Parametrised AXI4-Stream master video test-pattern generator. Successor to the fixed single-mode line source.
- Emits whole frames of PIXELS_VERTICAL lines × BEATS_PER_LINE beats. Marks start-of-frame on TUSER and end-of-line on TLAST.
- Programmable line and frame gaps, four selectable data patterns, start/stop control.
- Drives the slave stream input of the AXIS→AXI4 write path in simulation and bring-up builds.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32: stream width. Must be a multiple of 32.
- PIXELS_PER_BEAT, 4: pixels carried per beat.
- PIXELS_HORIZONTAL, 1280: pixels per line. Must be divisible by PIXELS_PER_BEAT.
- PIXELS_VERTICAL, 1024: lines per frame. Range 1..4095.
- LINE_GAP, 3: idle cycles between lines. 0 allowed.
- FRAME_GAP, 1000: idle cycles before the first line of every frame. 0 allowed.
- FRAME_CNT_W, 4: frame counter width.

Ports:
- M_AXIS_ACLK  in  1  clock
- M_AXIS_ARESETN  in  1  synchronous active-low reset
- enable  in  1  run request. Level-sensitive.
- mode  in  2  pattern select. Sampled at frame start only.
- M_AXIS_TVALID  out  1  beat valid
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  payload
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  all ones
- M_AXIS_TLAST  out  1  last beat of line
- M_AXIS_TUSER  out  1  first beat of frame (SOF)
- M_AXIS_TREADY  in  1  slave ready
- frame_done  out  1  one-cycle pulse on the handshake of the final beat of a frame
- frame_cnt  out  FRAME_CNT_W  completed frames. Wraps modulo 2^FRAME_CNT_W.
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset state (synchronous, ARESETN low at clock edge):
  - State = IDLE.
  - All counters = 0; LFSR = 32'hACE1_2468.
  - TVALID, TLAST, TUSER, frame_done, busy = 0; frame_cnt = 0.
  - Reset mid-frame aborts immediately. No partial-line completion.
- BEATS_PER_LINE = PIXELS_HORIZONTAL/PIXELS_PER_BEAT.
- Counters: beat (clog2 BEATS_PER_LINE bits), line (12 bits), gap (11 bits minimum, sized to max(LINE_GAP, FRAME_GAP)).
- States and transitions:
  - IDLE: if enable, latch mode into mode_q, clear line, load gap counter, go to FGAP.
  - FGAP: count FRAME_GAP cycles, then go to SEND. With FRAME_GAP = 0, IDLE goes directly to SEND.
  - SEND: TVALID = 1. A beat transfers when TVALID & TREADY; beat increments only on a transfer. On the TLAST transfer:
    - If line == PIXELS_VERTICAL-1: pulse frame_done, increment frame_cnt, line = 0. Go to FGAP (or SEND if FRAME_GAP = 0) when enable = 1, else IDLE. If enable = 1, re-latch mode.
    - Otherwise: line++, go to LGAP (or SEND if LINE_GAP = 0).
  - LGAP: count LINE_GAP cycles, then go to SEND.
- Output qualifiers:
  - TLAST = SEND & beat == BEATS_PER_LINE-1.
  - TUSER = SEND & line == 0 & beat == 0.
- Stopping: deasserting enable never truncates a frame. The current frame completes, then the block enters IDLE.
- Backpressure: TDATA, TLAST and TUSER are held stable while TVALID & !TREADY. TVALID never drops in SEND until TLAST transfers.
- Pattern word P (32 bits) is replicated C_M_AXIS_TDATA_WIDTH/32 times across TDATA:
  - mode 0 (counter): P = {frame_cnt[3:0] zero-extended to 4 bits, line[11:0], beat zero-extended to 16 bits}.
  - mode 1 (line ID): P = {20'h0, line[11:0]}.
  - mode 2 (checker): P = 32'hFFFF_FFFF if beat[0]^line[0], else 0.
  - mode 3 (PRBS): P = LFSR value. Polynomial x^32+x^22+x^2+x+1, Galois form. Advances only on transfer. Reseeds to 32'hACE1_2468 at every frame start.
- A change of mode mid-frame has no effect until the next frame start.
- Latency: first TVALID appears FRAME_GAP+1 cycles after the first enable-high edge in IDLE (exactly 1 cycle when FRAME_GAP = 0).

Decomposition:
- Package axis_gen_pkg holds:
  - state encoding: IDLE=0, FGAP=1, SEND=2, LGAP=3
  - mode constants: MODE_CNT, MODE_LINE, MODE_CHK, MODE_PRBS
  - LFSR seed and tap constants
  - clogb2 function
- One sub-module, axis_pattern_word: combinational pattern mux plus a registered LFSR with advance and reseed inputs.

Test Plan:
- Config H=16, PPB=4, V=3, LINE_GAP=2, FRAME_GAP=5, mode 0, TREADY=1, enable pulsed high for 1 cycle → exactly 12 beats. TUSER only on beat 1. TLAST on beats 4, 8, 12. First TDATA = 32'h0000_0000, last = 32'h0002_0003. frame_done pulses once, frame_cnt = 1, then IDLE.
- Same config, TREADY toggled by a random 50% pattern → identical data sequence. TDATA, TLAST and TUSER stable during every stall. No beat lost or duplicated.
- enable held high, mode changed 0→1 during line 1 → frame 0 stays mode 0. Frame 1 line 2 carries 32'h0000_0002 on all 4 beats. Frame 1 TUSER starts 5 gap cycles after frame 0's last TLAST transfer.
- LINE_GAP=0, FRAME_GAP=0, enable high → TVALID continuous across line and frame boundaries, back-to-back TLAST/TUSER beats, no idle cycle.
- mode 3 over two frames → first beat of each frame = 32'hACE1_2468. The second beat matches the reference LFSR step. Sequences of the two frames are identical.
- ARESETN low for 1 cycle mid-line 1 → next cycle TVALID=0, frame_cnt=0, busy=0. A new enable restarts at line 0 with TUSER=1.
